axis_fifo_ver2: RTL and testbench

AXIS_FIFO_VER2 -- requirements
Module: axis_fifo_ver2

---
 rtl/axis_fifo_ver2.sv | 123 ++++++++++++
 tb/tb_axis_fifo_ver2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_ver2.sv
// AXI-Stream style FIFO with a registered output stage; CAP = 2^ADDR_WIDTH words including the output register.
// Optional synchronous flush port enabled by defining AXIS_FIFO_FLUSH_EN.
module axis_fifo_ver2 #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = (1 << ADDR_WIDTH) - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [ADDR_WIDTH:0]   size,
  output logic                  afull,
  output logic                  aempty
`ifdef AXIS_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int CAP = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CAP_L    = (ADDR_WIDTH+1)'(CAP);
  localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [CAP];
  logic [DATA_WIDTH-1:0] odata_reg;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_WIDTH:0]   size_reg, size_next;
  logic                  ovalid_reg, ovalid_next;
  logic                  iready_reg, iready_next;
  logic                  flush_req;
  logic                  in_fire, out_fire;
  logic                  mem_empty, load_out, load_mem, load_bypass;

`ifdef AXIS_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // RAM holds every word not yet in the output register, so its occupancy is size - ovalid.
  always_comb begin
    in_fire     = ivalid && iready_reg;
    out_fire    = ovalid_reg && oready;
    mem_empty   = (size_reg == {{ADDR_WIDTH{1'b0}}, ovalid_reg});
    load_out    = !ovalid_reg || oready;
    load_mem    = load_out && !mem_empty;
    load_bypass = load_out && mem_empty && in_fire;

    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    ovalid_next = ovalid_reg;
    size_next   = size_reg;

    if (in_fire)
      wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);

    // A bypassed word is still written to RAM, so the read pointer steps past it too.
    if (load_mem || load_bypass) begin
      rd_ptr_next = rd_ptr_reg + ADDR_WIDTH'(1);
      ovalid_next = 1'b1;
    end else if (load_out) begin
      ovalid_next = 1'b0;
    end

    unique case ({in_fire, out_fire})
      2'b10:   size_next = size_reg + (ADDR_WIDTH+1)'(1);
      2'b01:   size_next = size_reg - (ADDR_WIDTH+1)'(1);
      default: size_next = size_reg;
    endcase

    iready_next = (size_next < CAP_L);

    if (flush_req) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      ovalid_next = 1'b0;
      size_next   = '0;
      iready_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      size_reg   <= '0;
      ovalid_reg <= 1'b0;
      iready_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      size_reg   <= size_next;
      ovalid_reg <= ovalid_next;
      iready_reg <= iready_next;
    end
  end

  // Storage and output data carry no reset so the array maps onto RAM primitives.
  always_ff @(posedge clock) begin
    if (in_fire)
      mem[wr_ptr_reg] <= idata;
    if (load_mem)
      odata_reg <= mem[rd_ptr_reg];
    else if (load_bypass)
      odata_reg <= idata;
  end

  assign iready = iready_reg;
  assign ovalid = ovalid_reg;
  assign odata  = odata_reg;
  assign size   = size_reg;
  assign afull  = (size_reg >= AFULL_L);
  assign aempty = (size_reg <= AEMPTY_L);

endmodule

// File: tb/tb_axis_fifo_ver2.sv
// Self-checking bench for axis_fifo_ver2 (CAP=4) against a queue-based reference model.
// Exercises the flush port as well when AXIS_FIFO_FLUSH_EN is defined.
module tb_axis_fifo_ver2;
  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int CAP = 4;
  localparam int AFL = 3;
  localparam int AEL = 1;

  logic          clock  = 1'b0;
  logic          resetn = 1'b1;
  logic [DW-1:0] idata  = '0;
  logic          ivalid = 1'b0;
  logic          iready;
  logic [DW-1:0] odata;
  logic          ovalid;
  logic          oready = 1'b0;
  logic [AW:0]   size;
  logic          afull;
  logic          aempty;
`ifdef AXIS_FIFO_FLUSH_EN
  logic          flush  = 1'b0;
`endif

  int            vectors     = 0;
  int            miscompares = 0;
  logic [7:0]    q[$];
  bit            rst_pending = 1'b0;

  always #5 clock = ~clock;

  axis_fifo_ver2 #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .AFULL_LEVEL (AFL),
    .AEMPTY_LEVEL(AEL)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .idata (idata),
    .ivalid(ivalid),
    .iready(iready),
    .odata (odata),
    .ovalid(ovalid),
    .oready(oready),
    .size  (size),
    .afull (afull),
    .aempty(aempty)
`ifdef AXIS_FIFO_FLUSH_EN
    ,
    .flush (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare outputs to the model, advance the model at posedge.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                      output bit acc, output bit pop);
    bit m_iready;
    @(negedge clock);
    ivalid = iv;
    idata  = d;
    oready = ordy;
`ifdef AXIS_FIFO_FLUSH_EN
    flush  = fl;
`endif
    #1;
    m_iready = !rst_pending && (q.size() < CAP);
    check("iready", 32'(iready), 32'(m_iready));
    check("ovalid", 32'(ovalid), 32'(q.size() > 0));
    check("size",   32'(size),   32'(q.size()));
    check("afull",  32'(afull),  32'(q.size() >= AFL));
    check("aempty", 32'(aempty), 32'(q.size() <= AEL));
    if (q.size() > 0)
      check("odata", 32'(odata), 32'(q[0]));
    acc = iv && m_iready;
    pop = ordy && (q.size() > 0);
    @(posedge clock);
    rst_pending = 1'b0;
    if (pop) begin
      $display("xfer out 0x%02h (held %0d)", q[0], q.size());
      void'(q.pop_front());
    end
    if (fl)
      q.delete();
    else if (acc)
      q.push_back(d);
  endtask

  task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy);
    bit a, p;
    step(iv, d, ordy, 1'b0, a, p);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_size"},   32'(size),   32'd0);
    check({tag, "_ovalid"}, 32'(ovalid), 32'd0);
    check({tag, "_iready"}, 32'(iready), 32'd0);
    check({tag, "_afull"},  32'(afull),  32'd0);
    check({tag, "_aempty"}, 32'(aempty), 32'd1);
  endtask

  initial begin
    logic [7:0] fill_v[5];
    int sent, rcvd, budget;
    bit a, p;
    fill_v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    #3 resetn = 1'b0;
    #1 check_reset_state("por");
    rst_pending = 1'b1;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);

    // Fill to full with the output stalled; the fifth push must be ignored.
    foreach (fill_v[i]) cyc(1'b1, fill_v[i], 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    repeat (5) cyc(1'b0, 8'h00, 1'b1);

    // Streaming through an empty FIFO wraps the pointers five times.
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1);

    // Random backpressure with a scoreboarded run of 64 words.
    sent = 0; rcvd = 0; budget = 0;
    while ((sent < 64 || q.size() > 0) && budget < 2000) begin
      step(sent < 64 && $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b0, a, p);
      sent += int'(a);
      rcvd += int'(p);
      budget++;
    end
    check("bp_words_out", 32'(rcvd), 32'd64);

    // Asynchronous reset with three words held.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h61 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    #3 resetn = 1'b0;
    #1 check_reset_state("midrst");
    q.delete();
    rst_pending = 1'b1;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    check("post_rst_odata", 32'(odata), 32'h0000_00A5);
    repeat (2) cyc(1'b0, 8'h00, 1'b1);

`ifdef AXIS_FIFO_FLUSH_EN
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, a, p);
    flush = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    check("flush_iready", 32'(iready), 32'd1);
    cyc(1'b1, 8'h88, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
